// File: rtl/byp_hazard_ctrl_pkg.sv
// Shared constants and types for the ID-stage hazard/bypass controller.
// Covers register address width, the R0 index, the NOP control bundle and the per-cycle action.
package byp_hazard_ctrl_pkg;

   localparam int RA_W_DEF = 4;
   localparam int R0_IDX   = 0;

   typedef struct packed {
      logic we;
      logic ld;
   } ctl_t;

   localparam ctl_t NOP_CTL = '{we: 1'b0, ld: 1'b0};

   // What the pipe does this cycle, in priority order (freeze highest).
   typedef enum logic [1:0] {
      ACT_RUN    = 2'd0,
      ACT_LUH    = 2'd1,
      ACT_FLUSH  = 2'd2,
      ACT_FREEZE = 2'd3
   } act_t;

endpackage

// File: rtl/byp_hazard_ctrl_hz_shadow_stage.sv
// One shadow stage of in-flight instruction tracking.
// Hold wins over clear, and clear loads the NOP bundle.
module hz_shadow_stage #(
   parameter int             W       = 6,
   parameter logic [W-1:0]   CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (!hold) begin
         if (clear) q <= CLR_VAL;
         else       q <= d;
      end
   end

endmodule

// File: rtl/byp_hazard_ctrl.sv
// ID-stage hazard and bypass controller for the ID/EX/DM/WB pipeline.
// Produces the load-use stall, flush bubble, memory freeze and registered EX bypass selects.
module byp_hazard_ctrl
   import byp_hazard_ctrl_pkg::*;
#(
   parameter int RA_W = RA_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [RA_W-1:0] p0_addr,
   input  logic [RA_W-1:0] p1_addr,
   input  logic            re0,
   input  logic            re1,
   input  logic [RA_W-1:0] dst_addr,
   input  logic            rf_we_ID,
   input  logic            mem_rd_ID,
   input  logic            flush,
   input  logic            mem_stall,
   output logic            byp0_EX,
   output logic            byp0_DM,
   output logic            byp1_EX,
   output logic            byp1_DM,
   output logic            stall_PC,
   output logic            stall_IF_ID,
   output logic            stall_ID_EX,
   output logic            stall_EX_DM,
   output logic            stall_DM_WB,
   output logic            bubble_ID_EX,
   output logic            rf_we_DM_WB,
   output logic [RA_W-1:0] dst_DM_WB_addr
);

   localparam int IDW = RA_W + 2;
   localparam int DSW = RA_W + 1;

   ctl_t            id_ctl;
   ctl_t            id_ex_ctl;
   logic [RA_W-1:0] id_ex_dst;
   logic [IDW-1:0]  id_ex_q;
   logic [RA_W-1:0] ex_dm_dst;
   logic            ex_dm_we;
   logic [DSW-1:0]  ex_dm_q;
   logic [DSW-1:0]  dm_wb_q;
   logic            m0_ex, m0_dm, m1_ex, m1_dm;
   logic            luh;
   act_t            act;
   logic            bubble_int;
   logic            freeze;

   function automatic logic match(input logic [RA_W-1:0] a, input logic re,
                                  input logic we, input logic [RA_W-1:0] dst);
      return re & we & (dst == a) & (a != RA_W'(R0_IDX));
   endfunction

   assign id_ctl = '{we: rf_we_ID, ld: mem_rd_ID};
   assign {id_ex_dst, id_ex_ctl} = id_ex_q;
   assign {ex_dm_dst, ex_dm_we}  = ex_dm_q;

   // The load flag only matters while the producer sits in ID_EX, so later stages carry {dst,we}.
   hz_shadow_stage #(.W(IDW), .CLR_VAL({RA_W'(R0_IDX), NOP_CTL})) u_id_ex (
      .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(bubble_int),
      .d({dst_addr, id_ctl}), .q(id_ex_q)
   );

   hz_shadow_stage #(.W(DSW)) u_ex_dm (
      .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(1'b0),
      .d({id_ex_dst, id_ex_ctl.we}), .q(ex_dm_q)
   );

   hz_shadow_stage #(.W(DSW)) u_dm_wb (
      .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(1'b0),
      .d(ex_dm_q), .q(dm_wb_q)
   );

   assign m0_ex = match(p0_addr, re0, id_ex_ctl.we, id_ex_dst);
   assign m1_ex = match(p1_addr, re1, id_ex_ctl.we, id_ex_dst);
   assign m0_dm = match(p0_addr, re0, ex_dm_we, ex_dm_dst);
   assign m1_dm = match(p1_addr, re1, ex_dm_we, ex_dm_dst);
   assign luh   = id_ex_ctl.ld & (m0_ex | m1_ex);

   always_comb begin
      act = ACT_RUN;
      if (mem_stall)  act = ACT_FREEZE;
      else if (flush) act = ACT_FLUSH;
      else if (luh)   act = ACT_LUH;
   end

   assign freeze     = (act == ACT_FREEZE);
   assign bubble_int = (act == ACT_FLUSH) | (act == ACT_LUH);

   // Gated with rst_n so every output reads 0 while reset is asserted.
   assign stall_PC     = rst_n & (freeze | (act == ACT_LUH));
   assign stall_IF_ID  = rst_n & (freeze | (act == ACT_LUH));
   assign stall_ID_EX  = rst_n & freeze;
   assign stall_EX_DM  = rst_n & freeze;
   assign stall_DM_WB  = rst_n & freeze;
   assign bubble_ID_EX = rst_n & bubble_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp0_EX <= 1'b0;
         byp0_DM <= 1'b0;
         byp1_EX <= 1'b0;
         byp1_DM <= 1'b0;
      end else if (act == ACT_RUN) begin
         byp0_EX <= m0_ex;
         byp0_DM <= m0_dm & ~m0_ex;
         byp1_EX <= m1_ex;
         byp1_DM <= m1_dm & ~m1_ex;
      end else if (!freeze) begin
         byp0_EX <= 1'b0;
         byp0_DM <= 1'b0;
         byp1_EX <= 1'b0;
         byp1_DM <= 1'b0;
      end
   end

   assign {dst_DM_WB_addr, rf_we_DM_WB} = dm_wb_q;

endmodule

// File: tb/tb_byp_hazard_ctrl.sv
// Bench for byp_hazard_ctrl: directed cycle table, reset corner sequence,
// then random traffic against an in-flight instruction queue model.
module tb_byp_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] p0_addr, p1_addr, dst_addr;
   logic       re0, re1, rf_we_ID, mem_rd_ID, flush, mem_stall;
   logic       byp0_EX, byp0_DM, byp1_EX, byp1_DM;
   logic       stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB;
   logic       bubble_ID_EX, rf_we_DM_WB;
   logic [3:0] dst_DM_WB_addr;

   always #5 clk = ~clk;

   byp_hazard_ctrl #(.RA_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
      .dst_addr(dst_addr), .rf_we_ID(rf_we_ID), .mem_rd_ID(mem_rd_ID),
      .flush(flush), .mem_stall(mem_stall),
      .byp0_EX(byp0_EX), .byp0_DM(byp0_DM), .byp1_EX(byp1_EX), .byp1_DM(byp1_DM),
      .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
      .stall_EX_DM(stall_EX_DM), .stall_DM_WB(stall_DM_WB),
      .bubble_ID_EX(bubble_ID_EX), .rf_we_DM_WB(rf_we_DM_WB),
      .dst_DM_WB_addr(dst_DM_WB_addr)
   );

   // exp layout: {byp0_EX,byp0_DM,byp1_EX,byp1_DM, PC,IF_ID,ID_EX,EX_DM,DM_WB, bubble, wb_we, wb_dst}
   typedef struct {
      logic [3:0]  p0, p1;
      logic        re0, re1;
      logic [3:0]  dst;
      logic        we, ld, fl, ms;
      logic [14:0] exp;
   } vec_t;

   typedef struct packed {
      logic [3:0] dst;
      logic       we;
      logic       ld;
   } ins_t;

   localparam int NVEC = 25;
   vec_t tbl[NVEC];
   int   n_vec = 0;
   int   n_bad = 0;

   ins_t       pipe_q[$];   // [0]=ID_EX, [1]=EX_DM, [2]=DM_WB
   logic [3:0] m_byp;

   function automatic vec_t mk(input logic [3:0] p0, input logic [3:0] p1,
                               input logic re0, input logic re1,
                               input logic [3:0] dst, input logic we, input logic ld,
                               input logic fl, input logic ms,
                               input logic [3:0] byp, input logic [4:0] stl,
                               input logic bub, input logic wbwe, input logic [3:0] wbdst);
      vec_t v;
      v.p0 = p0; v.p1 = p1; v.re0 = re0; v.re1 = re1;
      v.dst = dst; v.we = we; v.ld = ld; v.fl = fl; v.ms = ms;
      v.exp = {byp, stl, bub, wbwe, wbdst};
      return v;
   endfunction

   function automatic logic [14:0] actual();
      return {byp0_EX, byp0_DM, byp1_EX, byp1_DM,
              stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB,
              bubble_ID_EX, rf_we_DM_WB, dst_DM_WB_addr};
   endfunction

   task automatic check(input logic [14:0] exp, input string name);
      logic [14:0] got;
      got = actual();
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      p0_addr = v.p0; p1_addr = v.p1; re0 = v.re0; re1 = v.re1;
      dst_addr = v.dst; rf_we_ID = v.we; mem_rd_ID = v.ld;
      flush = v.fl; mem_stall = v.ms;
   endtask

   function automatic bit reads(input logic [3:0] a, input logic re, input ins_t i);
      return re && i.we && (i.dst == a) && (a != 0);
   endfunction

   task automatic model_step_check(input string name);
      bit         luh, bub;
      bit         e0, e1, d0, d1;
      logic [4:0] stl;
      ins_t       nxt;
      luh = pipe_q[0].ld && (reads(p0_addr, re0, pipe_q[0]) || reads(p1_addr, re1, pipe_q[0]));
      bub = 1'b0;
      stl = 5'b00000;
      if (mem_stall)  stl = 5'b11111;
      else if (flush) bub = 1'b1;
      else if (luh) begin stl = 5'b11000; bub = 1'b1; end
      check({m_byp, stl, bub, pipe_q[2].we, pipe_q[2].dst}, name);
      if (!mem_stall) begin
         e0 = reads(p0_addr, re0, pipe_q[0]);
         e1 = reads(p1_addr, re1, pipe_q[0]);
         d0 = reads(p0_addr, re0, pipe_q[1]) && !e0;
         d1 = reads(p1_addr, re1, pipe_q[1]) && !e1;
         m_byp = bub ? 4'b0000 : {e0, d0, e1, d1};
         nxt = bub ? ins_t'(6'd0) : ins_t'({dst_addr, rf_we_ID, mem_rd_ID});
         void'(pipe_q.pop_back());
         pipe_q.push_front(nxt);
      end
   endtask

   initial begin
      vec_t nopv;
      nopv = mk(0,0,0,0,0,0,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[0]  = mk(1,2,1,1, 3,1,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[1]  = mk(3,0,1,1, 6,1,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[2]  = mk(0,0,0,0, 0,0,0,0,0, 4'b1000,5'b00000,0,0,0);
      tbl[3]  = mk(0,0,0,0, 5,1,0,0,0, 4'b0000,5'b00000,0,1,3);
      tbl[4]  = mk(1,0,1,0, 7,1,0,0,0, 4'b0000,5'b00000,0,1,6);
      tbl[5]  = mk(2,5,1,1, 8,1,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[6]  = mk(0,0,0,0, 0,0,0,0,0, 4'b0001,5'b00000,0,1,5);
      tbl[7]  = mk(1,0,1,0, 2,1,1,0,0, 4'b0000,5'b00000,0,1,7);
      tbl[8]  = mk(2,0,1,1, 9,1,0,0,0, 4'b0000,5'b11000,1,1,8);
      tbl[9]  = mk(2,0,1,1, 9,1,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[10] = mk(0,0,0,0, 0,0,0,0,0, 4'b0100,5'b00000,0,1,2);
      tbl[11] = mk(0,0,0,0, 0,1,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[12] = mk(0,0,1,1,10,1,0,0,0, 4'b0000,5'b00000,0,1,9);
      tbl[13] = mk(0,0,0,0, 0,0,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[14] = mk(1,0,1,0, 4,1,1,0,0, 4'b0000,5'b00000,0,1,0);
      tbl[15] = mk(0,4,0,1,11,1,0,1,0, 4'b0000,5'b00000,1,1,10);
      tbl[16] = mk(0,0,0,0, 0,0,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[17] = mk(1,0,1,0,12,1,1,0,0, 4'b0000,5'b00000,0,1,4);
      tbl[18] = mk(12,0,1,0,13,1,0,0,1, 4'b0000,5'b11111,0,0,0);
      tbl[19] = mk(12,0,1,0,13,1,0,0,1, 4'b0000,5'b11111,0,0,0);
      tbl[20] = mk(12,0,1,0,13,1,0,0,1, 4'b0000,5'b11111,0,0,0);
      tbl[21] = mk(12,0,1,0,13,1,0,0,0, 4'b0000,5'b11000,1,0,0);
      tbl[22] = mk(12,0,1,0,13,1,0,0,0, 4'b0000,5'b00000,0,0,0);
      tbl[23] = mk(0,0,0,0, 0,0,0,0,1, 4'b0100,5'b11111,0,1,12);
      tbl[24] = mk(0,0,0,0, 0,0,0,0,0, 4'b0100,5'b00000,0,1,12);

      // clock/reset: outputs must read 0 in reset even with mem_stall high
      drive(nopv);
      mem_stall = 1'b1;
      repeat (2) @(posedge clk);
      #4 check(15'd0, "reset_hold");
      mem_stall = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      #3 check(15'd0, "after_release");
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i]);
         #3 check(tbl[i].exp, $sformatf("row%0d", i));
         @(posedge clk); #1;
      end

      // async reset while a bypass is live and the pipe is frozen
      drive(mk(1,2,1,1, 3,1,0,0,0, 4'b0000,5'b00000,0,0,0));
      @(posedge clk); #1;
      drive(mk(3,0,1,0, 5,1,0,0,0, 4'b0000,5'b00000,0,0,0));
      @(posedge clk); #1;
      drive(nopv);
      mem_stall = 1'b1;
      #1 check({4'b1000, 5'b11111, 1'b0, 1'b0, 4'd0}, "pre_reset");
      #1 rst_n = 1'b0;
      #1 check(15'd0, "reset_async");
      @(posedge clk); #1;
      mem_stall = 1'b0;
      rst_n = 1'b1;
      #3 check(15'd0, "post_reset");
      @(posedge clk); #1;

      pipe_q = {}; 
      for (int k = 0; k < 3; k++) pipe_q.push_back(ins_t'(6'd0));
      m_byp = 4'b0000;
      for (int n = 0; n < 400; n++) begin
         p0_addr   = 4'($urandom_range(0, 5));
         p1_addr   = 4'($urandom_range(0, 5));
         re0       = ($urandom_range(0, 3) != 0);
         re1       = ($urandom_range(0, 3) != 0);
         dst_addr  = 4'($urandom_range(0, 5));
         rf_we_ID  = ($urandom_range(0, 3) != 0);
         mem_rd_ID = rf_we_ID && ($urandom_range(0, 2) == 0);
         flush     = ($urandom_range(0, 9) == 0);
         mem_stall = ($urandom_range(0, 7) == 0);
         #3 model_step_check($sformatf("rand%0d", n));
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/byp_hazard_ctrl.md
Name: byp_hazard_ctrl

Overview:
- ID-stage hazard and bypass controller for the 4-stage pipeline (ID, EX, DM, WB).
- Tracks destination register, RF write enable and load flag of in-flight instructions through ID_EX, EX_DM and DM_WB shadow flops.
- Produces registered bypass selects (byp0/1_EX, byp0/1_DM) that line up with _ID_EX operands in EX.
- Generates load-use stall/bubble, flush bubble and global memory-stall freeze.

Parameters:
- RA_W, 4, register address width (16 registers; R0 reads zero and is never a bypass target).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- p0_addr  input  RA_W  ID-stage source 0 register address
- p1_addr  input  RA_W  ID-stage source 1 register address
- re0, re1  input  1 each  ID instruction actually reads port 0 / port 1
- dst_addr  input  RA_W  ID-stage destination register
- rf_we_ID  input  1  ID instruction writes the RF
- mem_rd_ID  input  1  ID instruction is a load (LW)
- flush  input  1  taken branch/jump resolved in EX; kill the ID instruction
- mem_stall  input  1  data/instruction memory not ready; freeze the whole pipe
- byp0_EX, byp0_DM, byp1_EX, byp1_DM  output  1 each  registered bypass selects, valid in EX
- stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB  output  1 each  stage hold enables
- bubble_ID_EX  output  1  ID must load NOP controls (we=0, mem=0) into ID_EX
- rf_we_DM_WB  output  1  WB-stage RF write enable (for RF write port)
- dst_DM_WB_addr  output  RA_W  WB-stage write address

Behaviour:
- Reset (async, rst_n=0): all shadow flops and bypass flops clear to 0. All outputs read 0 while in reset and after release until new instructions are tracked.
- Shadow pipe: each cycle not frozen, {dst,we,ld}:
  - ID→ID_EX. The load is {0,0,0} when bubble_ID_EX=1.
  - ID_EX→EX_DM.
  - EX_DM→DM_WB.
- Match definition: match(a, re, stage) = re & we_stage & (dst_stage==a) & (a!=0).
- Bypass next values, computed in ID and flopped into EX alignment:
  - byp0_EX_n = match(p0_addr, re0, ID_EX). EX wins: byp0_DM_n = match(p0_addr, re0, EX_DM) & ~byp0_EX_n. Same rule for port 1.
  - A WB-stage write to the same register read in ID is handled inside the RF (write-before-read); no bypass.
- Load-use hazard: luh = ld_ID_EX & (match(p0_addr, re0, ID_EX) | match(p1_addr, re1, ID_EX)).
  - On luh: stall_PC=1, stall_IF_ID=1, bubble_ID_EX=1, stall_ID_EX=0.
  - Bypass flops load 0 that cycle.
  - Next cycle the load is in EX_DM, so the recomputed select is byp*_DM=1. Exactly one bubble per load-use.
- Flush: bubble_ID_EX=1, no PC/IF_ID stall, bypass flops load 0.
- mem_stall:
  - All stall_* outputs = 1, bubble_ID_EX = 0.
  - Shadow and bypass flops hold.
  - luh/flush are ignored that cycle and re-evaluated when mem_stall drops.
- Priority: mem_stall > flush > luh > normal. Flush with luh gives a bubble only, no stall.
- Stall outputs and bubble are combinational from current inputs and shadow state.
- Latency: bypass selects one cycle after ID evaluation.

Decomposition:
- Shared params include: RA_W, R0 index, and a NOP control bundle constant.
- One natural sub-module, hz_shadow_stage: one stage of {dst,we,ld} with hold/clear and async reset, instantiated three times.

Test Plan:
- Back-to-back ADD R3 ← ..., then ADD .. ← R3 on p0 → byp0_EX=1 in the second instruction's EX cycle, others 0, no stall.
- Producer R5, independent instruction, consumer of R5 on p1 → byp1_DM=1, byp1_EX=0.
- LW R2 then ADD reading R2 on p0:
  - One cycle of stall_PC=stall_IF_ID=bubble_ID_EX=1.
  - Next cycle byp0_DM=1 in EX.
  - Exactly one bubble.
- Producer writes R0, consumer reads R0 → all bypass 0.
- LW R4 / use R4 with flush=1 in the same cycle → bubble_ID_EX=1, stall_PC=0.
- mem_stall=1 for 3 cycles mid-hazard:
  - All stall_*=1 and bypass outputs frozen.
  - After release the pending hazard resolves identically.
  - Asserting rst_n=0 mid-sequence clears all outputs immediately.
